// File: rtl/taylor_pkg.sv
// Shared definitions for the cosine Taylor-series datapath: fixed-point
// format constants, the Q2.23 angle type and the range-reducer state encoding.
package taylor_pkg;

    localparam int W         = 25;
    localparam int FXP_SHIFT = 23;
    localparam int FXP_MUL   = 8388608;

    // pi/2 in Q2.23, rounded to nearest
    localparam logic [W-1:0] PI_HALF = 25'h0C90FDB;

    typedef logic [W-1:0] angle_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_DIV  = 3'd2,
        ST_FOLD = 3'd3,
        ST_DONE = 3'd4
    } arr_state_t;

endpackage

// File: rtl/angle_range_reducer.sv
// Reduces a signed Q8.23 angle to r in [0, pi/2] (Q2.23) plus a negate flag
// such that cos(angle_in) = (negate_out ? -1 : 1) * cos(angle_out).
// |angle_in| is divided by pi/2 with an 8-step restoring division; the low
// two quotient bits select the quadrant fold.
module angle_range_reducer
    import taylor_pkg::*;
#(
    parameter int W_IN   = 32,
    parameter int Q_BITS = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [W_IN-1:0] angle_in,
    output logic            ready_out,
    output logic [W-1:0]    angle_out,
    output logic            negate_out
);

    localparam int REM_W = W_IN - 1;
    localparam int K_W   = $clog2(Q_BITS);

    arr_state_t        state_r;
    arr_state_t        state_nxt_s;
    logic [REM_W-1:0]  rem_r;
    logic [REM_W-1:0]  rem_nxt_s;
    logic [Q_BITS-1:0] q_r;
    logic [Q_BITS-1:0] q_nxt_s;
    logic [K_W-1:0]    k_r;
    logic [K_W-1:0]    k_nxt_s;
    logic              ready_nxt_s;
    angle_t            angle_nxt_s;
    logic              negate_nxt_s;

    logic [W_IN-1:0]   neg_in_s;
    logic [REM_W-1:0]  abs_s;
    logic [REM_W-1:0]  trial_s;

    assign neg_in_s = (~angle_in) + {{(W_IN-1){1'b0}}, 1'b1};
    assign trial_s  = {{(REM_W-W){1'b0}}, PI_HALF} << k_r;

    // Magnitude of the input; the most negative code saturates to the largest positive one
    always_comb begin
        abs_s = angle_in[REM_W-1:0];
        if (angle_in == {1'b1, {(W_IN-1){1'b0}}}) begin
            abs_s = {REM_W{1'b1}};
        end else if (angle_in[W_IN-1]) begin
            abs_s = neg_in_s[REM_W-1:0];
        end else begin
            abs_s = angle_in[REM_W-1:0];
        end
    end

    // Next-state, divider step and quadrant fold
    always_comb begin
        state_nxt_s  = state_r;
        rem_nxt_s    = rem_r;
        q_nxt_s      = q_r;
        k_nxt_s      = k_r;
        ready_nxt_s  = ready_out;
        angle_nxt_s  = angle_out;
        negate_nxt_s = negate_out;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                ready_nxt_s = 1'b0;
                rem_nxt_s   = abs_s;
                q_nxt_s     = {Q_BITS{1'b0}};
                k_nxt_s     = K_W'(Q_BITS - 1);
                state_nxt_s = ST_DIV;
            end
            ST_DIV: begin
                if (rem_r >= trial_s) begin
                    rem_nxt_s = rem_r - trial_s;
                    q_nxt_s   = q_r | ({{(Q_BITS-1){1'b0}}, 1'b1} << k_r);
                end else begin
                    rem_nxt_s = rem_r;
                    q_nxt_s   = q_r;
                end
                if (k_r == {K_W{1'b0}}) begin
                    state_nxt_s = ST_FOLD;
                end else begin
                    k_nxt_s     = k_r - {{(K_W-1){1'b0}}, 1'b1};
                    state_nxt_s = ST_DIV;
                end
            end
            ST_FOLD: begin
                // rem < PI_HALF here, so neither branch can exceed 25 bits
                if (q_r[0]) begin
                    angle_nxt_s = PI_HALF - rem_r[W-1:0];
                end else begin
                    angle_nxt_s = rem_r[W-1:0];
                end
                negate_nxt_s = q_r[1] ^ q_r[0];
                ready_nxt_s  = 1'b1;
                state_nxt_s  = ST_DONE;
            end
            ST_DONE: begin
                if (start) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs; reset discards any job in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            rem_r      <= {REM_W{1'b0}};
            q_r        <= {Q_BITS{1'b0}};
            k_r        <= {K_W{1'b0}};
            ready_out  <= 1'b0;
            angle_out  <= {W{1'b0}};
            negate_out <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            rem_r      <= rem_nxt_s;
            q_r        <= q_nxt_s;
            k_r        <= k_nxt_s;
            ready_out  <= ready_nxt_s;
            angle_out  <= angle_nxt_s;
            negate_out <= negate_nxt_s;
        end
    end

endmodule

// File: tb/tb_angle_range_reducer.sv
// Directed bench for angle_range_reducer: hand-computed reductions, latency,
// mid-job reset and the start/ready handshake.
module tb_angle_range_reducer;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] angle_in;
    logic        ready_out;
    logic [24:0] angle_out;
    logic        negate_out;

    int checks = 0;
    int errors = 0;

    angle_range_reducer dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .angle_in   (angle_in),
        .ready_out  (ready_out),
        .angle_out  (angle_out),
        .negate_out (negate_out)
    );

    // 10 ns clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Start a job from IDLE at a falling edge; E0 is the next rising edge.
    // angle_in is scrambled after E1 to confirm it is no longer sampled.
    task automatic run_job(input logic [31:0] a, input logic [31:0] exp_ang,
                           input logic exp_neg, input string tag);
        angle_in = a;
        start    = 1'b1;
        repeat (2) @(posedge clock);   // E0, E1
        @(negedge clock);
        angle_in = 32'h5A5A_1234;
        repeat (8) @(posedge clock);   // E2..E9
        @(negedge clock);
        check({tag, " ready_before_E10"}, {31'd0, ready_out}, 32'd0);
        @(posedge clock);              // E10
        @(negedge clock);
        check({tag, " ready"},  {31'd0, ready_out},  32'd1);
        check({tag, " angle"},  {7'd0, angle_out},   exp_ang);
        check({tag, " negate"}, {31'd0, negate_out}, {31'd0, exp_neg});
    endtask

    // Drop start in DONE and let the FSM return to IDLE
    task automatic release_start();
        start = 1'b0;
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        angle_in = 32'd0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset ready",  {31'd0, ready_out},  32'd0);
        check("reset angle",  {7'd0, angle_out},   32'd0);
        check("reset negate", {31'd0, negate_out}, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        run_job(32'd0,          32'd0,        1'b0, "zero");
        release_start();
        check("idle keeps ready", {31'd0, ready_out}, 32'd1);
        run_job(-32'sd8388608,  32'd8388608,  1'b0, "minus_one");
        release_start();
        run_job(32'd26353589,   32'd1,        1'b1, "pi");
        release_start();
        run_job(-32'sd26353589, 32'd1,        1'b1, "minus_pi");
        release_start();
        run_job(32'd16777216,   32'd9576374,  1'b1, "two");
        release_start();
        run_job(32'h8000_0000,  32'd12842857, 1'b1, "saturate");
        release_start();
        run_job(32'd13176795,   32'd13176795, 1'b1, "exact_pi_half");
        release_start();
        run_job(32'd26353590,   32'd0,        1'b1, "exact_pi");
        release_start();
        run_job(32'd16777216,   32'd9576374,  1'b1, "two_again");
        release_start();

        // Mid-job reset: start a job and reset while the divider is at k==3
        angle_in = 32'd26353589;
        start    = 1'b1;
        repeat (6) @(posedge clock);   // E0..E5
        @(negedge clock);
        start = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("midreset ready",  {31'd0, ready_out},  32'd0);
        check("midreset angle",  {7'd0, angle_out},   32'd0);
        check("midreset negate", {31'd0, negate_out}, 32'd0);
        repeat (12) @(posedge clock);
        @(negedge clock);
        check("midreset no_partial", {31'd0, ready_out}, 32'd0);
        check("midreset angle_held", {7'd0, angle_out},  32'd0);

        // Handshake: start held high through DONE must not restart
        run_job(32'd16777216, 32'd9576374, 1'b1, "hold");
        repeat (15) @(posedge clock);
        @(negedge clock);
        check("hold ready",  {31'd0, ready_out},  32'd1);
        check("hold angle",  {7'd0, angle_out},   32'd9576374);
        check("hold negate", {31'd0, negate_out}, 32'd1);
        release_start();
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("idle ready",  {31'd0, ready_out}, 32'd1);
        check("idle angle",  {7'd0, angle_out},  32'd9576374);
        run_job(-32'sd8388608, 32'd8388608, 1'b0, "restart");
        release_start();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
